// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_frame_monitor - recovers pixel x/y from a VGA stream, checks sync timing
// and blanking, and signs every frame. Define VGA_MON_CRC_EN for a CRC-16-CCITT
// signature instead of the additive sum. Rev 1.0
// ----------------------------------------------------------------------------
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [15:0] frame_count,
  output logic        timing_err,
  output logic        blank_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

`ifdef VGA_MON_CRC_EN
  localparam logic [15:0] SIG_INIT = 16'hFFFF;

  // Twelve serial CCITT steps unrolled, RGB MSB first.
  function automatic logic [15:0] crc12(input logic [15:0] crc, input logic [11:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGN    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state;
  logic        hs_prev;
  logic        vs_prev;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [15:0] sig_acc;

  logic        hs_fall;
  logic        hs_rise;
  logic        vs_fall;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [11:0] rgb;
  logic        active;
  logic        checking;
  logic        violation;
  logic [15:0] sig_next;

  // h_next/v_next are the coordinates of the pixel on the bus this strobe.
  always_comb begin
    rgb      = {VGA_R, VGA_G, VGA_B};
    hs_fall  = hs_prev & ~hSync;
    hs_rise  = ~hs_prev & hSync;
    vs_fall  = vs_prev & ~vSync;
    h_next   = hs_fall ? 10'd0 : h_cnt + 10'd1;
    v_next   = v_cnt;
    if (vs_fall)      v_next = 10'd0;
    else if (hs_fall) v_next = v_cnt + 10'd1;
    active   = (h_next >= H_ACT_START) && (h_next < H_ACT_END) &&
               (v_next >= V_ACT_START) && (v_next < V_ACT_END);
    checking = (state != UNLOCKED);
    violation = checking && ((hs_rise && (h_next != H_SYNC_END)) ||
                             (hs_fall && (h_cnt  != H_LAST))     ||
                             (vs_fall && (v_cnt  != V_LAST)));
`ifdef VGA_MON_CRC_EN
    sig_next = crc12(sig_acc, rgb);
`else
    sig_next = sig_acc + {4'h0, rgb};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNLOCKED;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      sig_acc     <= SIG_INIT;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 9'd0;
      pix_rgb     <= 12'h000;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_sig   <= 16'h0000;
      frame_count <= 16'h0000;
      timing_err  <= 1'b0;
      blank_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      if (pix_en) begin
        hs_prev   <= hSync;
        vs_prev   <= vSync;
        h_cnt     <= h_next;
        v_cnt     <= v_next;
        pix_valid <= active && checking;
        if (active && checking) begin
          pix_x   <= h_next - H_ACT_START;
          pix_y   <= 9'(v_next - V_ACT_START);
          pix_rgb <= rgb;
        end
        if (vs_fall)     sig_acc <= SIG_INIT;
        else if (active) sig_acc <= sig_next;
        if ((state == LOCKED) && !active && (rgb != 12'h000)) blank_err <= 1'b1;
        if (violation) begin
          state      <= UNLOCKED;
          locked     <= 1'b0;
          timing_err <= 1'b1;
        end else if (vs_fall) begin
          case (state)
            UNLOCKED: state <= ALIGN;
            ALIGN, LOCKED: begin
              state       <= LOCKED;
              locked      <= 1'b1;
              frame_done  <= 1'b1;
              frame_sig   <= sig_acc;
              frame_count <= frame_count + 16'd1;
            end
            default: begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// tb_vga_frame_monitor - directed bench on a scaled-down raster (15x9 total,
// 8x4 active, active at col 5..12 / line 4..7) so whole frames stay short.
module tb_vga_frame_monitor;

  localparam int H_ACTIVE = 8;
  localparam int H_FRONT  = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BACK   = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 2;
  localparam int H_TOTAL  = 15;
  localparam int V_TOTAL  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        hSync = 1'b1;
  logic        vSync = 1'b1;
  logic [3:0]  VGA_R = 4'h0;
  logic [3:0]  VGA_G = 4'h0;
  logic [3:0]  VGA_B = 4'h0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic [15:0] frame_count;
  logic        timing_err;
  logic        blank_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int terr_cnt = 0;

  int          sp_line = -1;
  int          sp_col = -1;
  logic [11:0] sp_rgb = 12'h000;
  logic [11:0] fg = 12'h000;
  int          short_line = -1;

  int          cap_l [4];
  int          cap_c [4];
  logic        cap_valid [4];
  logic [9:0]  cap_x [4];
  logic [8:0]  cap_y [4];
  logic [11:0] cap_rgb [4];
  logic        cap_terr [4];
  logic        cap_berr [4];
  logic        cap_lock [4];

  vga_frame_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_sig(frame_sig),
    .frame_count(frame_count), .timing_err(timing_err), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  // Pulse counters: a stuck-high pulse shows up as an overcount.
  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (timing_err) terr_cnt <= terr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 4; k++) begin
      cap_l[k] = -1;
      cap_c[k] = -1;
    end
  endtask

  // One strobe, then one idle clock so outputs must hold with pix_en low.
  task automatic send_pix(input int l, input int c);
    logic [11:0] v;
    @(negedge clk);
    hSync = (c >= H_SYNC);
    vSync = (l >= V_SYNC);
    if (l == sp_line && c == sp_col)             v = sp_rgb;
    else if (l >= 4 && l < 8 && c >= 5 && c < 13) v = fg;
    else                                          v = 12'h000;
    {VGA_R, VGA_G, VGA_B} = v;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (cap_l[k] == l && cap_c[k] == c) begin
        cap_valid[k] = pix_valid;
        cap_x[k]     = pix_x;
        cap_y[k]     = pix_y;
        cap_rgb[k]   = pix_rgb;
        cap_terr[k]  = timing_err;
        cap_berr[k]  = blank_err;
        cap_lock[k]  = locked;
      end
    end
    @(negedge clk);
  endtask

  task automatic edge_pix();
    send_pix(0, 0);
  endtask

  task automatic send_range(input int l0, input int l1);
    for (int l = l0; l <= l1; l++) begin
      for (int c = 0; c < ((l == short_line) ? H_TOTAL - 1 : H_TOTAL); c++) begin
        if (!(l == 0 && c == 0)) send_pix(l, c);
      end
    end
  endtask

  initial begin
    clear_caps();
    repeat (3) @(negedge clk);
    chk("rst_pix",   {pix_valid, pix_x, pix_y, pix_rgb}, 32'h0);
    chk("rst_frame", {frame_sig, frame_count}, 32'h0);
    chk("rst_flags", {locked, frame_done, timing_err, blank_err}, 32'h0);
    reset = 1'b0;

    // Black frames: lock at the 2nd vSync edge.
    edge_pix();
    chk("e1_locked", locked, 0);
    chk("e1_done", done_cnt, 0);
    send_range(0, V_TOTAL - 1);
    edge_pix();
    chk("e2_locked", locked, 1);
    chk("e2_done", done_cnt, 1);
    chk("e2_count", frame_count, 1);
    chk("e2_sig", frame_sig, 16'h0000);
    send_range(0, V_TOTAL - 1);
    edge_pix();
    chk("e3_done", done_cnt, 2);
    chk("e3_count", frame_count, 2);
    chk("e3_sig", frame_sig, 16'h0000);
    chk("e3_terr", terr_cnt, 0);

    // 0xABC everywhere active, white first pixel: 31*0xABC+0xFFF mod 2^16 = 0x5CC3.
    fg = 12'hABC; sp_line = 4; sp_col = 5; sp_rgb = 12'hFFF;
    cap_l[0] = 4; cap_c[0] = 5;  cap_l[1] = 7; cap_c[1] = 12;  cap_l[2] = 4; cap_c[2] = 13;
    send_range(0, V_TOTAL - 1);
    chk("f3_first_px", {cap_valid[0], cap_x[0], cap_y[0], cap_rgb[0]}, {1'b1, 10'd0, 9'd0, 12'hFFF});
    chk("f3_last_px",  {cap_valid[1], cap_x[1], cap_y[1], cap_rgb[1]}, {1'b1, 10'd7, 9'd3, 12'hABC});
    chk("f3_porch_valid", cap_valid[2], 0);
    edge_pix();
    chk("e4_sig", frame_sig, 16'h5CC3);
    chk("e4_count", frame_count, 3);
    chk("e4_done", done_cnt, 3);

    fg = 12'h001; sp_line = -1; sp_col = -1; clear_caps();
    send_range(0, V_TOTAL - 1);
    edge_pix();
    chk("e5_sig", frame_sig, 16'h0020);
    chk("e5_count", frame_count, 4);

    // Line 5 is one pixel short: error at the start of line 6.
    fg = 12'h002; short_line = 5;
    cap_l[0] = 6; cap_c[0] = 0;  cap_l[1] = 7; cap_c[1] = 5;
    send_range(0, V_TOTAL - 1);
    chk("f5_terr_pulse", cap_terr[0], 1);
    chk("f5_unlocked", cap_lock[0], 0);
    chk("f5_valid_unlocked", cap_valid[1], 0);
    chk("f5_terr_cnt", terr_cnt, 1);
    short_line = -1; clear_caps();
    edge_pix();
    chk("e6_done", done_cnt, 4);
    chk("e6_sig_kept", frame_sig, 16'h0020);
    chk("e6_count", frame_count, 4);
    chk("e6_locked", locked, 0);

    // Nonzero porch pixel while aligning must not set blank_err.
    fg = 12'h001; sp_line = 5; sp_col = 14; sp_rgb = 12'h00F;
    send_range(0, V_TOTAL - 1);
    edge_pix();
    chk("e7_locked", locked, 1);
    chk("e7_done", done_cnt, 5);
    chk("e7_count", frame_count, 5);
    chk("e7_sig", frame_sig, 16'h0020);
    chk("e7_berr", blank_err, 0);

    fg = 12'h003; sp_line = 5; sp_col = 13; sp_rgb = 12'h00F;
    cap_l[0] = 5; cap_c[0] = 12;  cap_l[1] = 5; cap_c[1] = 13;
    send_range(0, V_TOTAL - 1);
    chk("f7_berr_before", cap_berr[0], 0);
    chk("f7_berr_set", cap_berr[1], 1);
    edge_pix();
    chk("e8_sig", frame_sig, 16'h0060);
    chk("e8_count", frame_count, 6);
    chk("e8_berr_sticky", blank_err, 1);
    chk("e8_done", done_cnt, 6);

    // One-clock reset in the middle of a frame.
    fg = 12'h001; sp_line = -1; sp_col = -1; clear_caps();
    send_range(0, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_pix",   {pix_valid, pix_x, pix_y, pix_rgb}, 32'h0);
    chk("rst2_frame", {frame_sig, frame_count}, 32'h0);
    chk("rst2_flags", {locked, frame_done, timing_err, blank_err}, 32'h0);
    send_range(5, V_TOTAL - 1);
    edge_pix();
    chk("e9_locked", locked, 0);
    chk("e9_done", done_cnt, 6);
    send_range(0, V_TOTAL - 1);
    edge_pix();
    chk("e10_locked", locked, 1);
    chk("e10_count", frame_count, 1);
    chk("e10_sig", frame_sig, 16'h0020);
    chk("e10_berr", blank_err, 0);
    chk("e10_done", done_cnt, 7);
    chk("total_terr", terr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
